// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if
// AHB-lite slave register port bundle for the interrupt aggregator.
//
// Signals:
//   haddr_ahb       AHB address (only [4:2] decoded by the slave)
//   hwdata_ahb      AHB write data, data phase
//   hrdata_ahb      AHB read data, registered by the slave
//   hwrite_ahb      1 = write transfer
//   htrans_ahb      transfer type (bit 1 set = NONSEQ/SEQ)
//   hsel_ahb        slave select
//   hready_out_ahb  slave ready (constant 1, zero wait states)
//   hresp_ahb       slave response (constant 0, OKAY)
//
// Modports: master drives the request side, slave drives the response side.
// -----------------------------------------------------------------------------
interface irq_ctrl_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] haddr_ahb;
   logic [31:0]           hwdata_ahb;
   logic [31:0]           hrdata_ahb;
   logic                  hwrite_ahb;
   logic [1:0]            htrans_ahb;
   logic                  hsel_ahb;
   logic                  hready_out_ahb;
   logic                  hresp_ahb;

   modport master (
      output haddr_ahb, hwdata_ahb, hwrite_ahb, htrans_ahb, hsel_ahb,
      input  hrdata_ahb, hready_out_ahb, hresp_ahb
   );

   modport slave (
      input  haddr_ahb, hwdata_ahb, hwrite_ahb, htrans_ahb, hsel_ahb,
      output hrdata_ahb, hready_out_ahb, hresp_ahb
   );
endinterface

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Interrupt aggregator feeding the CPU core's 8-bit interrupt input. Each of
// up to 8 source lines is synchronised, optionally edge-detected into a
// software-clearable pending latch, masked by ENABLE and registered onto
// irq_out together with an OR (irq_valid) and a lowest-index encode (irq_id).
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   irq_src    raw interrupt sources [NUM_IRQ-1:0]
//   bus        AHB-lite slave register port (irq_ctrl_if.slave)
//   irq_out    registered pending & enable, bits >= NUM_IRQ are 0
//   irq_valid  registered OR of irq_out
//   irq_id     registered index of lowest set bit of irq_out, 0 when none
//
// Register map (offset = haddr[4:2]*4):
//   0x00 STATUS  RO raw pending, write-1-clears edge-mode bits
//   0x04 ENABLE  RW
//   0x08 EDGE_SEL RW (1 = edge mode)
//   0x0C ACTIVE  RO {irq_valid[31], irq_id[2:0]}
//   0x10 MASKED  RO irq_out
//
// Build option: define IRQ_CTRL_SYNC_EN to insert a 2-flop synchroniser on
// irq_src (edge latency 3). Without it a single sampling flop forms s2 for
// sources already in the clk domain (edge latency 2).
// -----------------------------------------------------------------------------
module irq_ctrl #(
   parameter int NUM_IRQ    = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_src,
   irq_ctrl_if.slave          bus,
   output logic [7:0]         irq_out,
   output logic               irq_valid,
   output logic [2:0]         irq_id
);

   // Bits of every 8-bit register that correspond to implemented lines.
   localparam logic [7:0] LINE_MASK =
      (NUM_IRQ >= 8) ? 8'hFF : 8'((9'd1 << NUM_IRQ) - 9'd1);

   localparam logic [2:0] A_STATUS   = 3'd0;
   localparam logic [2:0] A_ENABLE   = 3'd1;
   localparam logic [2:0] A_EDGE_SEL = 3'd2;
   localparam logic [2:0] A_ACTIVE   = 3'd3;
   localparam logic [2:0] A_MASKED   = 3'd4;

   logic [7:0] src_ext;
   logic [7:0] s2_reg;
   logic [7:0] s2_d_reg;
   logic [7:0] rise;
   logic [7:0] enable_reg,   enable_next;
   logic [7:0] edge_sel_reg, edge_sel_next;
   logic [7:0] edge_pend_reg, edge_pend_next;
   logic [7:0] pending;
   logic [7:0] status_post;
   logic [7:0] masked;
   logic [2:0] id_next;

   logic [ADDR_WIDTH-1:0] haddr;
   logic       addr_accept;
   logic       dp_valid_reg;
   logic       dp_write_reg;
   logic [2:0] dp_addr_reg;
   logic       wr_en;
   logic [7:0] wdata;
   logic [7:0] w1c;
   logic [31:0] rd_data;
   logic [31:0] hrdata_reg;
   logic       unused_bits;

   // ---------------------------------------------------------------- sources
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_src
         if (gi < NUM_IRQ) begin : g_used
            assign src_ext[gi] = irq_src[gi];
         end else begin : g_tie
            assign src_ext[gi] = 1'b0;
         end
      end
   endgenerate

`ifdef IRQ_CTRL_SYNC_EN
   logic [7:0] s1_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg <= '0;
         s2_reg <= '0;
      end else begin
         s1_reg <= src_ext;
         s2_reg <= s1_reg;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_reg <= '0;
      end else begin
         s2_reg <= src_ext;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_d_reg <= '0;
      end else begin
         s2_d_reg <= s2_reg;
      end
   end

   assign rise = s2_reg & ~s2_d_reg;

   // ---------------------------------------------------------------- AHB
   assign haddr              = bus.haddr_ahb;
   assign bus.hready_out_ahb = 1'b1;
   assign bus.hresp_ahb      = 1'b0;
   assign bus.hrdata_ahb     = hrdata_reg;

   assign addr_accept = bus.hsel_ahb & bus.htrans_ahb[1] & bus.hready_out_ahb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_valid_reg <= 1'b0;
         dp_write_reg <= 1'b0;
         dp_addr_reg  <= '0;
      end else begin
         dp_valid_reg <= addr_accept;
         dp_write_reg <= bus.hwrite_ahb;
         dp_addr_reg  <= haddr[4:2];
      end
   end

   assign wr_en = dp_valid_reg & dp_write_reg;
   assign wdata = bus.hwdata_ahb[7:0] & LINE_MASK;

   assign enable_next   = (wr_en && dp_addr_reg == A_ENABLE)   ? wdata : enable_reg;
   assign edge_sel_next = (wr_en && dp_addr_reg == A_EDGE_SEL) ? wdata : edge_sel_reg;
   assign w1c           = (wr_en && dp_addr_reg == A_STATUS)   ? wdata : 8'h00;

   // ---------------------------------------------------------------- per line
   // The stored edge bit is only meaningful in edge mode and is forced to 0
   // otherwise, so flipping the mode always starts from a clean latch.
   // A new edge is ORed in after the W1C term, so a same-cycle set wins.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_line
         assign edge_pend_next[gi] =
            (edge_sel_next[gi] != edge_sel_reg[gi]) ? 1'b0 :
            (edge_sel_reg[gi] & (rise[gi] | (edge_pend_reg[gi] & ~w1c[gi])));
         assign pending[gi] = edge_sel_reg[gi] ? edge_pend_reg[gi] : s2_reg[gi];
         // Read-back view of STATUS after any write committing this cycle.
         assign status_post[gi] = edge_sel_next[gi] ? edge_pend_next[gi] : s2_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_reg    <= '0;
         edge_sel_reg  <= '0;
         edge_pend_reg <= '0;
      end else begin
         enable_reg    <= enable_next;
         edge_sel_reg  <= edge_sel_next;
         edge_pend_reg <= edge_pend_next & LINE_MASK;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign masked = pending & enable_reg & LINE_MASK;

   // Walk from the top so the lowest-numbered set bit is the last to assign.
   always_comb begin
      id_next = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (masked[i]) id_next = 3'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_out   <= '0;
         irq_valid <= 1'b0;
         irq_id    <= '0;
      end else begin
         irq_out   <= masked;
         irq_valid <= |masked;
         irq_id    <= id_next;
      end
   end

   // ---------------------------------------------------------------- read
   // Read data is captured at the end of the address phase from the
   // post-write state, so a write immediately followed by a read of the
   // same register returns the newly written value.
   always_comb begin
      rd_data = '0;
      case (haddr[4:2])
         A_STATUS:   rd_data = {24'h0, status_post & LINE_MASK};
         A_ENABLE:   rd_data = {24'h0, enable_next};
         A_EDGE_SEL: rd_data = {24'h0, edge_sel_next};
         A_ACTIVE:   rd_data = {irq_valid, 28'h0, irq_id};
         A_MASKED:   rd_data = {24'h0, irq_out};
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hrdata_reg <= '0;
      end else if (addr_accept && !bus.hwrite_ahb) begin
         hrdata_reg <= rd_data;
      end else begin
         hrdata_reg <= '0;
      end
   end

   assign unused_bits = ^{bus.hwdata_ahb[31:8], bus.htrans_ahb[0],
                          haddr[ADDR_WIDTH-1:5], haddr[1:0]};

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
// Directed self-checking bench for irq_ctrl (NUM_IRQ = 8). Outputs are sampled
// 1 ns after the rising edge; inputs are driven at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   localparam logic [15:0] R_STATUS   = 16'h0000;
   localparam logic [15:0] R_ENABLE   = 16'h0004;
   localparam logic [15:0] R_EDGE_SEL = 16'h0008;
   localparam logic [15:0] R_ACTIVE   = 16'h000C;
   localparam logic [15:0] R_MASKED   = 16'h0010;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] irq_src = 8'h00;
   logic [7:0] irq_out;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic [31:0] rd;

   int total = 0;
   int bad   = 0;

   irq_ctrl_if #(.ADDR_WIDTH(16)) bus ();

   irq_ctrl #(.NUM_IRQ(8), .ADDR_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_src   (irq_src),
      .bus       (bus),
      .irq_out   (irq_out),
      .irq_valid (irq_valid),
      .irq_id    (irq_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.hsel_ahb   = 1'b0;
      bus.htrans_ahb = 2'b00;
      bus.hwrite_ahb = 1'b0;
      bus.haddr_ahb  = 16'h0;
      bus.hwdata_ahb = 32'h0;
   endtask

   task automatic ahb_write(input logic [15:0] addr, input logic [31:0] data);
      bus.hsel_ahb   = 1'b1;
      bus.htrans_ahb = 2'b10;
      bus.hwrite_ahb = 1'b1;
      bus.haddr_ahb  = addr;
      tick(1);
      bus_idle();
      bus.hwdata_ahb = data;
      tick(1);
      bus.hwdata_ahb = 32'h0;
      $display("write addr=%h data=%h", addr, data);
   endtask

   task automatic ahb_read(input logic [15:0] addr, output logic [31:0] data);
      bus.hsel_ahb   = 1'b1;
      bus.htrans_ahb = 2'b10;
      bus.hwrite_ahb = 1'b0;
      bus.haddr_ahb  = addr;
      tick(1);
      bus_idle();
      data = bus.hrdata_ahb;
      $display("read  addr=%h data=%h", addr, data);
   endtask

   initial begin
      bus_idle();

      // ---- power-on reset
      tick(3);
      chk("rst_irq_out", irq_out, 8'h00);
      chk("rst_irq_valid", irq_valid, 1'b0);
      chk("rst_irq_id", irq_id, 3'd0);
      chk("rst_hrdata", bus.hrdata_ahb, 32'h0);
      chk("hready", bus.hready_out_ahb, 1'b1);
      chk("hresp", bus.hresp_ahb, 1'b0);
      rst_n = 1'b1;
      tick(1);

      // ---- edge latch on line 0
      ahb_write(R_EDGE_SEL, 32'h01);
      ahb_write(R_ENABLE, 32'h01);
      irq_src = 8'h01;
      tick(1);                 // edge k samples the pulse
      irq_src = 8'h00;
      tick(LAT - 1);
      chk("edge_early", irq_out, 8'h00);
      tick(1);
      chk("edge_irq_out", irq_out, 8'h01);
      chk("edge_irq_valid", irq_valid, 1'b1);
      chk("edge_irq_id", irq_id, 3'd0);
      ahb_read(R_STATUS, rd);
      chk("edge_status", rd, 32'h01);
      ahb_write(R_STATUS, 32'h01);
      chk("w1c_hold", irq_out, 8'h01);
      tick(1);
      chk("w1c_irq_out", irq_out, 8'h00);
      ahb_read(R_STATUS, rd);
      chk("w1c_status", rd, 32'h00);
      ahb_write(R_EDGE_SEL, 32'h00);
      ahb_write(R_ENABLE, 32'h00);

      // ---- level mode
      ahb_write(R_ENABLE, 32'h06);
      irq_src = 8'h06;
      tick(LAT);
      chk("lvl_irq_out", irq_out, 8'h06);
      chk("lvl_irq_id", irq_id, 3'd1);
      chk("lvl_irq_valid", irq_valid, 1'b1);
      ahb_read(R_ACTIVE, rd);
      chk("lvl_active", rd, 32'h8000_0001);
      ahb_read(R_MASKED, rd);
      chk("lvl_masked", rd, 32'h06);
      irq_src = 8'h00;
      tick(LAT - 1);
      chk("lvl_drop_hold", irq_out, 8'h06);
      tick(1);
      chk("lvl_drop", irq_out, 8'h00);
      ahb_write(R_STATUS, 32'hFF);     // level bits ignore W1C, harmless
      ahb_write(R_ENABLE, 32'h00);

      // ---- masked edge on line 3
      ahb_write(R_EDGE_SEL, 32'h08);
      irq_src = 8'h08;
      tick(LAT + 1);
      chk("mask_irq_out", irq_out, 8'h00);
      ahb_read(R_STATUS, rd);
      chk("mask_status", rd, 32'h08);
      ahb_write(R_ENABLE, 32'h08);
      tick(1);
      chk("unmask_irq_out", irq_out, 8'h08);
      chk("unmask_irq_id", irq_id, 3'd3);
      irq_src = 8'h00;

      // ---- mode change clears stored pending; simultaneous set/W1C on line 2
      ahb_write(R_EDGE_SEL, 32'h04);
      ahb_read(R_STATUS, rd);
      chk("modechg_status", rd, 32'h00);
      irq_src = 8'h04;
      tick(LAT - 2);
      ahb_write(R_STATUS, 32'h04);     // commit edge coincides with rise
      ahb_read(R_STATUS, rd);
      chk("simul_status", rd, 32'h04);
      irq_src = 8'h00;
      tick(2);
      ahb_write(R_STATUS, 32'h04);
      ahb_read(R_STATUS, rd);
      chk("w1c2_status", rd, 32'h00);

      // ---- bus behaviour
      ahb_write(16'h0014, 32'hFFFF_FFFF);
      ahb_read(16'h0014, rd);
      chk("off14", rd, 32'h0);
      ahb_write(16'h001C, 32'hFFFF_FFFF);
      ahb_read(16'h001C, rd);
      chk("off1c", rd, 32'h0);
      chk("hready_run", bus.hready_out_ahb, 1'b1);
      chk("hresp_run", bus.hresp_ahb, 1'b0);
      ahb_write(R_ENABLE, 32'hFF);
      ahb_read(R_ENABLE, rd);
      chk("enable_ff", rd, 32'hFF);
      ahb_read(R_EDGE_SEL, rd);
      chk("edgesel_unaliased", rd, 32'h04);

      // IDLE and BUSY transfers must not write
      bus.hsel_ahb = 1'b1; bus.hwrite_ahb = 1'b1; bus.haddr_ahb = R_ENABLE;
      bus.htrans_ahb = 2'b00;
      tick(1);
      bus.htrans_ahb = 2'b01;
      bus.hwdata_ahb = 32'h0;
      tick(1);
      bus_idle();
      tick(1);
      ahb_read(R_ENABLE, rd);
      chk("idle_busy_nowrite", rd, 32'hFF);

      // back-to-back write then read of the same register
      bus.hsel_ahb = 1'b1; bus.htrans_ahb = 2'b10; bus.hwrite_ahb = 1'b1;
      bus.haddr_ahb = R_EDGE_SEL;
      tick(1);
      bus.hwdata_ahb = 32'h5A;
      bus.hwrite_ahb = 1'b0;
      bus.haddr_ahb  = R_EDGE_SEL;
      tick(1);
      bus_idle();
      rd = bus.hrdata_ahb;
      $display("b2b   addr=%h data=%h", R_EDGE_SEL, rd);
      chk("b2b_read", rd, 32'h5A);

      // ---- reset mid-run and mid-transfer
      irq_src = 8'hFF;
      tick(LAT + 1);
      chk("pre_rst_irq_out", irq_out, 8'hFF);
      bus.hsel_ahb = 1'b1; bus.htrans_ahb = 2'b10; bus.hwrite_ahb = 1'b1;
      bus.haddr_ahb = R_ENABLE;
      tick(1);                 // address phase accepted
      bus_idle();
      irq_src = 8'h00;
      bus.hwdata_ahb = 32'h33;
      rst_n = 1'b0;
      #1;
      chk("midrst_irq_out", irq_out, 8'h00);
      chk("midrst_irq_valid", irq_valid, 1'b0);
      chk("midrst_irq_id", irq_id, 3'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      bus.hwdata_ahb = 32'h0;
      ahb_read(R_STATUS, rd);
      chk("post_rst_status", rd, 32'h0);
      ahb_read(R_ENABLE, rd);
      chk("post_rst_enable", rd, 32'h0);
      ahb_read(R_EDGE_SEL, rd);
      chk("post_rst_edgesel", rd, 32'h0);
      ahb_read(R_ACTIVE, rd);
      chk("post_rst_active", rd, 32'h0);
      ahb_read(R_MASKED, rd);
      chk("post_rst_masked", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt aggregator that sits directly upstream of the CPU core's 8-bit interrupt input.
- Collects up to 8 peripheral interrupt lines, such as the UART interrupt and the 2-bit interrupt source outputs.
- Per-line features: synchronizer, edge/level detection, pending latch and enable mask.
- Drives a registered irq vector and a priority-encoded active ID; software access is through an AHB-lite slave register port on the same bus as the UART controller.

Parameters:
- NUM_IRQ, 8, number of interrupt source lines used (1..8); unused bits of irq_out tie to 0.
- ADDR_WIDTH, 16, width of haddr_ahb.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- irq_src  input  NUM_IRQ  raw interrupt sources, asynchronous to clk
- haddr_ahb  input  ADDR_WIDTH  AHB address; only bits [4:2] are decoded
- hwdata_ahb  input  32  AHB write data (data phase)
- hrdata_ahb  output  32  AHB read data
- hwrite_ahb  input  1  AHB write
- htrans_ahb  input  2  AHB transfer type
- hsel_ahb  input  1  slave select
- hready_out_ahb  output  1  always 1 (zero wait states)
- hresp_ahb  output  1  always 0 (OKAY)
- irq_out  output  8  to CPU irq input: pending & enable, registered
- irq_valid  output  1  OR of irq_out
- irq_id  output  3  index of lowest-numbered set bit of irq_out; 0 when none

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low. On reset all flops clear.
  - irq_out=0, irq_valid=0, irq_id=0, hrdata_ahb=0.
  - ENABLE=0, EDGE_SEL=0, pending=0, synchronizers=0.
- Source path: irq_src passes through a 2-flop synchronizer giving s2; s2_d is s2 delayed one cycle.
- Level mode (EDGE_SEL[i]=0): pending[i] = s2[i] combinationally; W1C has no effect.
- Edge mode (EDGE_SEL[i]=1):
  - s2 & ~s2_d sets pending[i] (registered), which holds until software clears it via W1C.
  - A set and a W1C in the same cycle: set wins.
- Changing EDGE_SEL[i] clears the stored edge pending bit for line i.
- Output: irq_out <= pending & ENABLE (registered); irq_valid and irq_id are registered in the same cycle as irq_out.
- Latency (edge mode):
  - source sampled high at edge k: s1 at k, s2 at k+1, pending at k+2, irq_out/irq_id at k+3.
- AHB-lite:
  - Address phase accepted when hsel_ahb & htrans_ahb[1] & hready_out_ahb; address and write flag are registered.
  - Write: hwdata_ahb is applied in the following (data-phase) cycle.
  - Read: hrdata_ahb is registered, valid in the data-phase cycle; otherwise hrdata_ahb holds 0.
  - IDLE/BUSY transfers and hsel_ahb=0 cause no access.
- Register map (offset = haddr_ahb[4:2]*4):
  - 0x00 STATUS: RO raw pending[NUM_IRQ-1:0]; write 1 clears edge-mode bits.
  - 0x04 ENABLE: RW [NUM_IRQ-1:0].
  - 0x08 EDGE_SEL: RW [NUM_IRQ-1:0].
  - 0x0C ACTIVE: RO {irq_valid at bit 31, irq_id at [2:0]}.
  - 0x10 MASKED: RO irq_out.
  - Other offsets: read 0, writes ignored, still OKAY.
  - Bits at or above NUM_IRQ read 0 and ignore writes.
- Back-to-back transfers: write to X followed by read of X returns the new value (write commits in the data-phase cycle, read data is registered from post-write state).
- Reset mid-transfer: the pending access is discarded; no register update.

Optional Feature:
- Macro: IRQ_CTRL_SYNC_EN.
- Defined: the 2-flop synchronizer is present; edge latency to irq_out is 3 cycles.
- Undefined: irq_src feeds s2 directly (for sources already in the clk domain); edge latency is 1 cycle shorter (2 cycles). All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-run -> irq_out=0x00, irq_id=0, irq_valid=0, and all registers read 0 after release.
- Edge latch: EDGE_SEL=0x01, ENABLE=0x01, pulse irq_src[0] for 1 cycle at edge k -> irq_out=0x01 at k+3 (macro on); STATUS reads 0x01; write STATUS=0x01 -> irq_out=0x00 one cycle after the data phase.
- Level: EDGE_SEL=0, ENABLE=0x06, hold irq_src=0x06 -> irq_out=0x06, irq_id=1, ACTIVE=0x80000001; drop irq_src -> irq_out=0x00 three cycles later.
- Mask: irq_src[3] edge with ENABLE=0 -> irq_out=0, STATUS bit3=1; then write ENABLE=0x08 -> irq_out=0x08, irq_id=3.
- Simultaneous: new edge on line 2 in the same cycle as a W1C of bit 2 -> STATUS bit2 stays 1.
- Bus: writes/reads at offsets 0x14 and 0x1C return 0, hresp_ahb=0 and hready_out_ahb=1 throughout; write ENABLE=0xFF then read back -> 0xFF (NUM_IRQ=8), 0x0F (NUM_IRQ=4).
